// File: rtl/dmem_bridge.sv
// dmem_bridge: single-outstanding bridge from the load/store unit to a req/gnt/rvalid data memory.
// Define DMEM_TIMEOUT_EN to bound the WAIT state by TIMEOUT_CYC cycles.
module dmem_bridge #(
  parameter int   ADDR_WIDTH  = 32,
  parameter int   DATA_WIDTH  = 32,
  parameter int   TIMEOUT_CYC = 255,
  parameter logic LS_LOAD     = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lsu_valid_i,
  output logic                  lsu_ready_o,
  input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
  input  logic                  lsu_ls_i,
  input  logic [1:0]            lsu_wdth_i,
  input  logic [DATA_WIDTH-1:0] lsu_stdat_i,
  output logic                  done_o,
  output logic                  err_o,
  output logic [DATA_WIDTH-1:0] ld_dat_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [3:0]            mem_wmask_o,
  output logic [DATA_WIDTH-1:0] mem_wdat_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdat_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  load_q, load_d;
  logic [3:0]            mask_q, mask_d;
  logic [DATA_WIDTH-1:0] wdat_q, wdat_d;
  logic [DATA_WIDTH-1:0] ldDat_q, ldDat_d;
  logic                  err_q, err_d;

  logic                  accLoad;
  logic                  accBad;
  logic [3:0]            accMask;
  logic [DATA_WIDTH-1:0] accWdat;
  logic [DATA_WIDTH-1:0] rdatAligned;

`ifdef DMEM_TIMEOUT_EN
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYC - 1);
  logic [7:0] toCnt_q, toCnt_d;
  logic       timeoutHit;
  assign timeoutHit = (toCnt_q == TimeoutLast);
`else
  logic unusedTimeoutCfg;
  assign unusedTimeoutCfg = (TIMEOUT_CYC > 0);
`endif

  // Lane steering and alignment check for the access offered by the LSU this cycle.
  always_comb begin
    accLoad = (lsu_ls_i == LS_LOAD);
    accBad  = 1'b0;
    accMask = 4'b0000;
    accWdat = lsu_stdat_i;
    case (lsu_wdth_i)
      2'b00: begin
        accMask = 4'b0001 << lsu_addr_i[1:0];
        accWdat = {4{lsu_stdat_i[7:0]}};
      end
      2'b01: begin
        accMask = 4'b0011 << lsu_addr_i[1:0];
        accWdat = {2{lsu_stdat_i[15:0]}};
        accBad  = lsu_addr_i[0];
      end
      2'b10: begin
        accMask = 4'b1111;
        accBad  = |lsu_addr_i[1:0];
      end
      default: accBad = 1'b1;
    endcase
    if (accLoad) accMask = 4'b0000;
  end

  assign rdatAligned = mem_rdat_i >> {addr_q[1:0], 3'b000};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    load_d  = load_q;
    mask_d  = mask_q;
    wdat_d  = wdat_q;
    ldDat_d = ldDat_q;
    err_d   = err_q;
`ifdef DMEM_TIMEOUT_EN
    toCnt_d = toCnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (lsu_valid_i) begin
          addr_d = lsu_addr_i;
          load_d = accLoad;
          mask_d = accMask;
          wdat_d = accWdat;
          if (accBad) begin
            state_d = S_DONE;
            err_d   = 1'b1;
            ldDat_d = '0;
          end else begin
            state_d = S_REQ;
            err_d   = 1'b0;
          end
        end
      end
      S_REQ: begin
        if (mem_gnt_i) begin
          if (!load_q) begin
            state_d = S_DONE;
          end else if (mem_rvalid_i) begin
            ldDat_d = rdatAligned;
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
`ifdef DMEM_TIMEOUT_EN
            toCnt_d = 8'd0;
`endif
          end
        end
      end
      S_WAIT: begin
        if (mem_rvalid_i) begin
          ldDat_d = rdatAligned;
          state_d = S_DONE;
`ifdef DMEM_TIMEOUT_EN
        end else if (timeoutHit) begin
          ldDat_d = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
`endif
        end
`ifdef DMEM_TIMEOUT_EN
        if (toCnt_q != 8'hFF) toCnt_d = toCnt_q + 8'd1;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Synchronous active-low reset returns to IDLE and clears every output-visible register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      load_q  <= 1'b0;
      mask_q  <= 4'b0000;
      wdat_q  <= '0;
      ldDat_q <= '0;
      err_q   <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
      toCnt_q <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      load_q  <= load_d;
      mask_q  <= mask_d;
      wdat_q  <= wdat_d;
      ldDat_q <= ldDat_d;
      err_q   <= err_d;
`ifdef DMEM_TIMEOUT_EN
      toCnt_q <= toCnt_d;
`endif
    end
  end

  assign lsu_ready_o = (state_q == S_IDLE);
  assign done_o      = (state_q == S_DONE);
  assign err_o       = (state_q == S_DONE) && err_q;
  assign ld_dat_o    = ldDat_q;
  assign mem_req_o   = (state_q == S_REQ);
  assign mem_we_o    = (state_q == S_REQ) && !load_q;
  assign mem_addr_o  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign mem_wmask_o = mask_q;
  assign mem_wdat_o  = wdat_q;

endmodule
